fifo_ctrl: RTL and testbench
============================

FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 Parameter SIZE_DEPTH, default 16, number of entries in the controlled memory array; SHALL equal 2**SIZE_ADDR.
REQ-002 Parameter SIZE_ADDR, default 4, memory address width.
REQ-003 Parameter ALMOST_LVL, default 2, distance from full/empty at which the almost flags assert; legal range 1..SIZE_DEPTH-1.
REQ-004 i_clk  input  1  sole clock, rising edge.
REQ-005 i_rst  input  1  reset, asynchronous, active-high.
REQ-006 i_push  input  1  write request.
REQ-007 i_pop  input  1  read request.
REQ-008 i_flush  input  1  synchronous flush; empties FIFO.
REQ-009 i_clr_err  input  1  synchronous clear of sticky error flags.
REQ-010 o_mem_wr_en  output  1  memory write enable, combinational.
REQ-011 o_mem_rd_en  output  1  memory read enable, combinational.
REQ-012 o_addr_wr  output  SIZE_ADDR  memory write address.
REQ-013 o_addr_rd  output  SIZE_ADDR  memory read address.
REQ-014 o_full, o_empty  output  1 each  status flags.
REQ-015 o_count  output  SIZE_ADDR+1  current occupancy, 0..SIZE_DEPTH.
REQ-016 o_ovf, o_unf  output  1 each  sticky overflow/underflow error flags.
REQ-017 o_almost_full, o_almost_empty  output  1 each  present only per REQ-035.

Function
REQ-018 Pointers: wr_ptr and rd_ptr SHALL be SIZE_ADDR+1 bits, the MSB being the wrap bit; o_addr_wr/o_addr_rd = low SIZE_ADDR bits.
REQ-019 o_empty SHALL be high iff wr_ptr == rd_ptr; o_full iff addresses are equal and wrap bits differ; both flags SHALL be registered-pointer derived, never from request inputs.
REQ-020 pop_acc = i_pop & ~o_empty; push_acc = i_push & (~o_full | pop_acc).
REQ-021 o_mem_wr_en = push_acc and o_mem_rd_en = pop_acc, same cycle as the request (zero latency); addresses SHALL be valid in that cycle.
REQ-022 On each rising edge: push_acc increments wr_ptr by 1, pop_acc increments rd_ptr by 1, modulo 2**(SIZE_ADDR+1).
REQ-023 o_count SHALL equal wr_ptr - rd_ptr (modulo 2**(SIZE_ADDR+1)), updated on the same edge as the pointers.
REQ-024 Full with push and pop same cycle: both accepted, o_count unchanged, o_full stays high.
REQ-025 Empty with push and pop same cycle: pop rejected, push accepted, o_unf set, o_count becomes 1.
REQ-026 o_ovf SHALL set on the edge after i_push=1 with push_acc=0; o_unf on the edge after i_pop=1 with pop_acc=0; both hold until i_clr_err or reset.
REQ-027 i_clr_err SHALL clear both error flags; a new error in the same cycle SHALL win (flag stays set).
REQ-028 i_flush SHALL, on the next edge, set wr_ptr = rd_ptr = 0; during a flush cycle o_mem_wr_en and o_mem_rd_en SHALL be forced low and no error flags SHALL be set; error flags otherwise unaffected.
REQ-029 Pointer wrap from address SIZE_DEPTH-1 to 0 SHALL toggle the wrap bit with no gap cycle.

Reset
REQ-030 i_rst high SHALL immediately, without a clock edge, force wr_ptr = rd_ptr = 0, o_count = 0, o_empty = 1, o_full = 0, o_ovf = o_unf = 0.
REQ-031 During reset, o_mem_wr_en and o_mem_rd_en SHALL be 0; o_addr_wr = o_addr_rd = 0.
REQ-032 Reset asserted mid-operation SHALL discard all contents; first accepted push after deassertion SHALL write address 0.
REQ-033 Reset deassertion SHALL be assumed synchronous to i_clk; no requests are accepted on the edge on which i_rst is high.

Configuration
REQ-034 Macro FIFO_CTRL_ALMOST_FLAGS_EN SHALL select the almost-flag feature.
REQ-035 Defined: o_almost_full = (o_count >= SIZE_DEPTH-ALMOST_LVL), o_almost_empty = (o_count <= ALMOST_LVL), registered, reset to 0 and 1 respectively. Undefined: both ports and their logic absent; all other behaviour identical.

Verification
REQ-036 Reset, push 16 consecutive cycles -> addresses 0..15, o_full=1 after 16th edge, o_count=16, o_ovf=0.
REQ-037 Full, push only -> o_mem_wr_en=0, o_ovf=1 next edge; i_clr_err -> o_ovf=0.
REQ-038 Full, push+pop same cycle -> both enables 1, o_count=16, wr and rd addresses wrap 15->0 with wrap bits toggled.
REQ-039 Empty, push+pop same cycle -> o_mem_rd_en=0, o_unf=1, o_count=1, o_empty=0.
REQ-040 Count=5, i_flush with i_push=1 -> no write, o_count=0, o_empty=1; then i_rst pulse between edges -> outputs at reset values before next edge.
REQ-041 With FIFO_CTRL_ALMOST_FLAGS_EN, ALMOST_LVL=2 -> o_almost_empty falls at count 3, o_almost_full rises at count 14.

Source files
------------

// File: rtl/fifo_ctrl.sv
// FIFO pointer/flag controller for an external SIZE_DEPTH-entry memory with zero-latency enables.
// Define FIFO_CTRL_ALMOST_FLAGS_EN to add registered almost-full/almost-empty outputs.
module fifo_ctrl #(
    parameter int SIZE_DEPTH = 16,
    parameter int SIZE_ADDR  = 4,
    parameter int ALMOST_LVL = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_push,
    input  logic                 i_pop,
    input  logic                 i_flush,
    input  logic                 i_clr_err,
    output logic                 o_mem_wr_en,
    output logic                 o_mem_rd_en,
    output logic [SIZE_ADDR-1:0] o_addr_wr,
    output logic [SIZE_ADDR-1:0] o_addr_rd,
    output logic                 o_full,
    output logic                 o_empty,
    output logic [SIZE_ADDR:0]   o_count,
    output logic                 o_ovf,
    output logic                 o_unf
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
    ,
    output logic                 o_almost_full,
    output logic                 o_almost_empty
`endif
);

    typedef logic [SIZE_ADDR:0] ptr_t;

    if (SIZE_DEPTH != 2 ** SIZE_ADDR) begin : g_bad_depth
        $error("fifo_ctrl: SIZE_DEPTH must equal 2**SIZE_ADDR");
    end
    if (ALMOST_LVL < 1 || ALMOST_LVL > SIZE_DEPTH - 1) begin : g_bad_lvl
        $error("fifo_ctrl: ALMOST_LVL out of range");
    end

    ptr_t wr_ptr;
    ptr_t rd_ptr;
    ptr_t wr_next;
    ptr_t rd_next;
    logic push_acc;
    logic pop_acc;
    logic ovf_next;
    logic unf_next;

    // Flags come only from the registered pointers; the MSB is the wrap bit.
    assign o_addr_wr = wr_ptr[SIZE_ADDR-1:0];
    assign o_addr_rd = rd_ptr[SIZE_ADDR-1:0];
    assign o_empty   = (wr_ptr == rd_ptr);
    assign o_full    = (wr_ptr[SIZE_ADDR] != rd_ptr[SIZE_ADDR]) &&
                       (wr_ptr[SIZE_ADDR-1:0] == rd_ptr[SIZE_ADDR-1:0]);
    assign o_count   = wr_ptr - rd_ptr;

    // A push into a full FIFO is still accepted when a pop frees a slot in the same cycle.
    always_comb begin
        pop_acc     = i_pop & ~o_empty;
        push_acc    = i_push & (~o_full | pop_acc);
        o_mem_wr_en = push_acc & ~i_flush & ~i_rst;
        o_mem_rd_en = pop_acc & ~i_flush & ~i_rst;

        wr_next = wr_ptr;
        rd_next = rd_ptr;
        if (i_flush) begin
            wr_next = '0;
            rd_next = '0;
        end else begin
            if (push_acc) wr_next = wr_ptr + ptr_t'(1);
            if (pop_acc)  rd_next = rd_ptr + ptr_t'(1);
        end

        // A fresh error outranks a clear issued in the same cycle; flush never raises one.
        ovf_next = (i_push & ~push_acc & ~i_flush) | (o_ovf & ~i_clr_err);
        unf_next = (i_pop & ~pop_acc & ~i_flush) | (o_unf & ~i_clr_err);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            o_ovf  <= 1'b0;
            o_unf  <= 1'b0;
        end else begin
            wr_ptr <= wr_next;
            rd_ptr <= rd_next;
            o_ovf  <= ovf_next;
            o_unf  <= unf_next;
        end
    end

`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
    localparam ptr_t AF_LVL = ptr_t'(SIZE_DEPTH - ALMOST_LVL);
    localparam ptr_t AE_LVL = ptr_t'(ALMOST_LVL);

    ptr_t count_next;
    assign count_next = wr_next - rd_next;

    // Registered from the next occupancy so the flags line up with o_count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_almost_full  <= 1'b0;
            o_almost_empty <= 1'b1;
        end else begin
            o_almost_full  <= (count_next >= AF_LVL);
            o_almost_empty <= (count_next <= AE_LVL);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Table-driven directed bench for fifo_ctrl (SIZE_DEPTH=16), plus hand sequences for async reset.
module tb_fifo_ctrl;

    logic       clk;
    logic       rst;
    logic       push;
    logic       pop;
    logic       flush;
    logic       clr_err;
    logic       mem_wr_en;
    logic       mem_rd_en;
    logic [3:0] addr_wr;
    logic [3:0] addr_rd;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       ovf;
    logic       unf;
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
    logic       almost_full;
    logic       almost_empty;
`endif

    int n_total = 0;
    int n_bad   = 0;

    fifo_ctrl #(.SIZE_DEPTH(16), .SIZE_ADDR(4), .ALMOST_LVL(2)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_push        (push),
        .i_pop         (pop),
        .i_flush       (flush),
        .i_clr_err     (clr_err),
        .o_mem_wr_en   (mem_wr_en),
        .o_mem_rd_en   (mem_rd_en),
        .o_addr_wr     (addr_wr),
        .o_addr_rd     (addr_rd),
        .o_full        (full),
        .o_empty       (empty),
        .o_count       (count),
        .o_ovf         (ovf),
        .o_unf         (unf)
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
        ,
        .o_almost_full (almost_full),
        .o_almost_empty(almost_empty)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       push, pop, flush, clr;
        logic       wr_en, rd_en;
        logic [3:0] aw, ar;
        logic [4:0] cnt;
        logic       full, empty, ovf, unf;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(string n, logic pu, logic po, logic fl, logic cl,
                                logic we, logic re, logic [3:0] aw, logic [3:0] ar,
                                logic [4:0] cnt, logic fu, logic em, logic ov, logic un);
        vec_t v;
        v.name = n; v.push = pu; v.pop = po; v.flush = fl; v.clr = cl;
        v.wr_en = we; v.rd_en = re; v.aw = aw; v.ar = ar;
        v.cnt = cnt; v.full = fu; v.empty = em; v.ovf = ov; v.unf = un;
        vecs.push_back(v);
    endfunction

    task automatic check_output(string name, logic [31:0] actual, logic [31:0] expected);
        n_total++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic check_reset_values(string tag);
        check_output({tag, ".count"}, 32'(count), 0);
        check_output({tag, ".empty"}, 32'(empty), 1);
        check_output({tag, ".full"}, 32'(full), 0);
        check_output({tag, ".ovf"}, 32'(ovf), 0);
        check_output({tag, ".unf"}, 32'(unf), 0);
        check_output({tag, ".wr_en"}, 32'(mem_wr_en), 0);
        check_output({tag, ".rd_en"}, 32'(mem_rd_en), 0);
        check_output({tag, ".addr_wr"}, 32'(addr_wr), 0);
        check_output({tag, ".addr_rd"}, 32'(addr_rd), 0);
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
        check_output({tag, ".almost_full"}, 32'(almost_full), 0);
        check_output({tag, ".almost_empty"}, 32'(almost_empty), 1);
`endif
    endtask

    // Drive between edges, check enables/addresses before the edge, state after it.
    task automatic apply_stimulus(vec_t v);
        @(negedge clk);
        push = v.push; pop = v.pop; flush = v.flush; clr_err = v.clr;
        #1;
        check_output({v.name, ".wr_en"}, 32'(mem_wr_en), 32'(v.wr_en));
        check_output({v.name, ".rd_en"}, 32'(mem_rd_en), 32'(v.rd_en));
        check_output({v.name, ".addr_wr"}, 32'(addr_wr), 32'(v.aw));
        check_output({v.name, ".addr_rd"}, 32'(addr_rd), 32'(v.ar));
        @(posedge clk);
        #1;
        check_output({v.name, ".count"}, 32'(count), 32'(v.cnt));
        check_output({v.name, ".full"}, 32'(full), 32'(v.full));
        check_output({v.name, ".empty"}, 32'(empty), 32'(v.empty));
        check_output({v.name, ".ovf"}, 32'(ovf), 32'(v.ovf));
        check_output({v.name, ".unf"}, 32'(unf), 32'(v.unf));
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
        check_output({v.name, ".almost_full"}, 32'(almost_full), 32'(v.cnt >= 5'd14));
        check_output({v.name, ".almost_empty"}, 32'(almost_empty), 32'(v.cnt <= 5'd2));
`endif
    endtask

    initial begin
        //  name          pu po fl cl  we re aw ar cnt full empty ovf unf
        for (int i = 0; i < 16; i++)
            add($sformatf("fill%0d", i), 1, 0, 0, 0, 1, 0, 4'(i), 0, 5'(i + 1), i == 15, 0, 0, 0);
        add("ovf_push",      1, 0, 0, 0, 0, 0, 0, 0, 16, 1, 0, 1, 0);
        add("ovf_clr_win",   1, 0, 0, 1, 0, 0, 0, 0, 16, 1, 0, 1, 0);
        add("ovf_clr",       0, 0, 0, 1, 0, 0, 0, 0, 16, 1, 0, 0, 0);
        for (int i = 0; i < 16; i++)
            add($sformatf("full_pp%0d", i), 1, 1, 0, 0, 1, 1, 4'(i), 4'(i), 16, 1, 0, 0, 0);
        for (int i = 0; i < 16; i++)
            add($sformatf("drain%0d", i), 0, 1, 0, 0, 0, 1, 0, 4'(i), 5'(15 - i), 0, i == 15, 0, 0);
        add("unf_pop",       0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        add("unf_clr_win",   0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        add("unf_clr",       0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        add("empty_pp",      1, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++)
            add($sformatf("to5_%0d", i), 1, 0, 0, 0, 1, 0, 4'(i + 1), 0, 5'(i + 2), 0, 0, 0, 1);
        add("flush_push",    1, 0, 1, 0, 0, 0, 5, 0, 0, 0, 1, 0, 1);
        add("post_flush_clr",0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        add("flush_pop_emp", 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        add("push_after_fl", 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);

        // Power-on reset with a push request held high.
        rst = 1'b1; push = 1'b1; pop = 1'b0; flush = 1'b0; clr_err = 1'b0;
        #1;
        check_reset_values("por");
        @(negedge clk);
        rst = 1'b0; push = 1'b0;

        for (int i = 0; i < vecs.size(); i++)
            apply_stimulus(vecs[i]);

        // Reset pulse between edges with requests pending: state must drop at once.
        @(negedge clk);
        push = 1'b1; pop = 1'b1; flush = 1'b0; clr_err = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check_reset_values("mid_rst");
        push = 1'b0; pop = 1'b0;
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_reset_values("after_rst_edge");

        begin
            vec_t v;
            v.name = "first_push_after_rst"; v.push = 1; v.pop = 0; v.flush = 0; v.clr = 0;
            v.wr_en = 1; v.rd_en = 0; v.aw = 0; v.ar = 0;
            v.cnt = 1; v.full = 0; v.empty = 0; v.ovf = 0; v.unf = 0;
            apply_stimulus(v);
        end

        @(negedge clk);
        push = 1'b0; pop = 1'b0; flush = 1'b0; clr_err = 1'b0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
